// File: rtl/id_stage_pipe_if.sv
// ---------------------------------------------------------------------------
// id_stage_pipe_if
// Bundles the fetch-side input handshake, the writeback port and the
// registered ID/EX output handshake of the decode stage.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer holds its payload stable while
// valid && !ready. ready may depend combinationally on valid-side state.
//
// Signals:
//   in_valid/in_ready, ins, pc       fetch -> decode instruction handshake
//   RegWrite, wb_rd, wd              writeback register-file write port
//   flush                            kill held and incoming instruction
//   out_valid/out_ready              decode -> execute handshake
//   rd1, rd2, immOut, branch,
//   jTarget, out_pc, out_rd,
//   out_rs1, out_rs2, out_is_load    ID/EX payload
//   out_illegal                      only when ID_ILLEGAL_TRAP_EN is defined
//
// Modports: slave = the decode stage, master = its environment.
// ---------------------------------------------------------------------------
interface id_stage_pipe_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     ins;
   logic [XLEN-1:0] pc;
   logic            RegWrite;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wd;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] rd1;
   logic [XLEN-1:0] rd2;
   logic [XLEN-1:0] immOut;
   logic [XLEN-1:0] branch;
   logic [XLEN-1:0] jTarget;
   logic [XLEN-1:0] out_pc;
   logic [4:0]      out_rd;
   logic [4:0]      out_rs1;
   logic [4:0]      out_rs2;
   logic            out_is_load;
`ifdef ID_ILLEGAL_TRAP_EN
   logic            out_illegal;
`endif

   modport slave (
      input  in_valid, ins, pc, RegWrite, wb_rd, wd, flush, out_ready,
`ifdef ID_ILLEGAL_TRAP_EN
      output out_illegal,
`endif
      output in_ready, out_valid, rd1, rd2, immOut, branch, jTarget,
             out_pc, out_rd, out_rs1, out_rs2, out_is_load
   );

   modport master (
      output in_valid, ins, pc, RegWrite, wb_rd, wd, flush, out_ready,
`ifdef ID_ILLEGAL_TRAP_EN
      input  out_illegal,
`endif
      input  in_ready, out_valid, rd1, rd2, immOut, branch, jTarget,
             out_pc, out_rd, out_rs1, out_rs2, out_is_load
   );
endinterface

// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------
// id_stage_pipe
// Pipelined RV32I/RV64I instruction-decode stage: register file with
// write-through bypass, immediate generation for every format, load-use
// bubble insertion, and a registered ID/EX stage with valid/ready.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears ID/EX, leaves register file alone
//   bus    id_stage_pipe_if.slave (fetch handshake, writeback port, flush,
//          ID/EX handshake and payload)
//
// Parameters:
//   XLEN   datapath width (32 or 64); immediates sign-extend to XLEN
//   NREG   architectural registers (32, or 16 for RV32E); only the low
//          clog2(NREG) address bits index the register file
//
// Optional feature macro: ID_ILLEGAL_TRAP_EN adds bus.out_illegal, set for
// unknown opcodes, ins[1:0]!=2'b11, or (NREG=16) a used register field >= 16.
// ---------------------------------------------------------------------------
module id_stage_pipe #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input logic          clk,
   input logic          reset,
   id_stage_pipe_if.slave bus
);
   localparam int AW = $clog2(NREG);

   typedef enum logic [2:0] {
      FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X
   } fmt_t;

   // ---------------- field extraction ----------------
   logic [6:0] opcode;
   logic [4:0] rs1, rs2, rd;
   assign opcode = bus.ins[6:0];
   assign rd     = bus.ins[11:7];
   assign rs1    = bus.ins[19:15];
   assign rs2    = bus.ins[24:20];

   fmt_t fmt;
   always_comb begin
      fmt = FMT_X;
      case (opcode)
         7'b0110011:                                     fmt = FMT_R;
         7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: fmt = FMT_I;
         7'b0100011:                                     fmt = FMT_S;
         7'b1100011:                                     fmt = FMT_B;
         7'b0110111, 7'b0010111:                         fmt = FMT_U;
         7'b1101111:                                     fmt = FMT_J;
         default:                                        fmt = FMT_X;
      endcase
   end

   logic uses_rs2;
   assign uses_rs2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);

   // ---------------- immediates ----------------
   // Narrow signed temporaries; the size cast to XLEN sign-extends them.
   logic signed [11:0] raw_i, raw_s;
   logic signed [12:0] raw_b;
   logic signed [31:0] raw_u;
   logic signed [20:0] raw_j;
   assign raw_i = bus.ins[31:20];
   assign raw_s = {bus.ins[31:25], bus.ins[11:7]};
   assign raw_b = {bus.ins[31], bus.ins[7], bus.ins[30:25], bus.ins[11:8], 1'b0};
   assign raw_u = {bus.ins[31:12], 12'b0};
   assign raw_j = {bus.ins[31], bus.ins[19:12], bus.ins[20], bus.ins[30:21], 1'b0};

   logic [XLEN-1:0] imm_b, imm_j, imm_sel;
   assign imm_b = XLEN'(raw_b);
   assign imm_j = XLEN'(raw_j);

   always_comb begin
      imm_sel = '0;
      case (fmt)
         FMT_I:   imm_sel = XLEN'(raw_i);
         FMT_S:   imm_sel = XLEN'(raw_s);
         FMT_B:   imm_sel = imm_b;
         FMT_U:   imm_sel = XLEN'(raw_u);
         FMT_J:   imm_sel = imm_j;
         default: imm_sel = '0;
      endcase
   end

   // ---------------- register file with write-through bypass ----------------
   logic [XLEN-1:0] rf [NREG];
   logic [AW-1:0]   wa, ra1, ra2;
   logic            wr_en;
   assign wa    = bus.wb_rd[AW-1:0];
   assign ra1   = rs1[AW-1:0];
   assign ra2   = rs2[AW-1:0];
   assign wr_en = bus.RegWrite && (wa != '0);

   always_ff @(posedge clk) begin
      if (wr_en) rf[wa] <= bus.wd;
   end

   logic [XLEN-1:0] rdata1, rdata2;
   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      if (ra1 != '0) rdata1 = (wr_en && wa == ra1) ? bus.wd : rf[ra1];
      if (ra2 != '0) rdata2 = (wr_en && wa == ra2) ? bus.wd : rf[ra2];
   end

   // ---------------- ID/EX register and handshake ----------------
   logic            q_valid, q_is_load;
   logic [XLEN-1:0] q_rd1, q_rd2, q_imm, q_branch, q_jtarget, q_pc;
   logic [4:0]      q_rd, q_rs1, q_rs2;

   logic advance, hazard, accept;
   assign advance = !q_valid || bus.out_ready;
   // The held load's data is not available until it reaches memory, so a
   // dependent instruction waits one cycle behind a bubble.
   assign hazard  = q_valid && q_is_load && (q_rd != 5'd0) &&
                    ((q_rd == rs1) || (uses_rs2 && (q_rd == rs2)));
   assign bus.in_ready = advance && !hazard && !bus.flush && !reset;
   assign accept  = bus.in_valid && bus.in_ready;

`ifdef ID_ILLEGAL_TRAP_EN
   logic illegal, q_illegal, bad_reg;
   always_comb begin
      bad_reg = 1'b0;
      if (NREG == 16) begin
         bad_reg = ((fmt == FMT_R || fmt == FMT_I || fmt == FMT_U || fmt == FMT_J) && rd[4]) ||
                   ((fmt == FMT_R || fmt == FMT_I || fmt == FMT_S || fmt == FMT_B) && rs1[4]) ||
                   (uses_rs2 && rs2[4]);
      end
   end
   assign illegal = (fmt == FMT_X) || (bus.ins[1:0] != 2'b11) || bad_reg;
   always_ff @(posedge clk) begin
      if (reset)                      q_illegal <= 1'b0;
      else if (!bus.flush && accept)  q_illegal <= illegal;
   end
   assign bus.out_illegal = q_illegal;
`else
   // Unknown opcodes pass down with immOut=0 and no trap indication.
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         q_valid   <= 1'b0;
         q_rd1     <= '0;
         q_rd2     <= '0;
         q_imm     <= '0;
         q_branch  <= '0;
         q_jtarget <= '0;
         q_pc      <= '0;
         q_rd      <= '0;
         q_rs1     <= '0;
         q_rs2     <= '0;
         q_is_load <= 1'b0;
      end else if (bus.flush) begin
         q_valid <= 1'b0;
      end else if (advance) begin
         // Advancing without an accept (hazard or idle fetch) leaves a bubble.
         q_valid <= accept;
         if (accept) begin
            q_rd1     <= rdata1;
            q_rd2     <= rdata2;
            q_imm     <= imm_sel;
            q_branch  <= imm_b;
            q_jtarget <= imm_j;
            q_pc      <= bus.pc;
            q_rd      <= rd;
            q_rs1     <= rs1;
            q_rs2     <= rs2;
            q_is_load <= (opcode == 7'b0000011);
         end
      end
   end

   assign bus.out_valid   = q_valid;
   assign bus.rd1         = q_rd1;
   assign bus.rd2         = q_rd2;
   assign bus.immOut      = q_imm;
   assign bus.branch      = q_branch;
   assign bus.jTarget     = q_jtarget;
   assign bus.out_pc      = q_pc;
   assign bus.out_rd      = q_rd;
   assign bus.out_rs1     = q_rs1;
   assign bus.out_rs2     = q_rs2;
   assign bus.out_is_load = q_is_load;
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Pipelined instruction-decode stage for the RV32I/RV64I CPU; successor to the single-cycle decoder.
- Contains the register file, write-through bypass, immediate generation for all formats and load-use bubble insertion.
- Ends in a registered ID/EX stage with a valid/ready handshake.
- Sits between the fetch stage (upstream) and execute (downstream); writeback drives the write port.

Parameters:
- XLEN, 32, datapath width; 32 or 64; all immediates sign-extended to XLEN.
- NREG, 32, architectural register count; 32 (RV32I) or 16 (RV32E); address width is clog2(NREG).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- ins  in  32  instruction word
- pc  in  XLEN  PC of ins
- RegWrite  in  1  writeback enable
- wb_rd  in  5  writeback destination
- wd  in  XLEN  writeback data
- flush  in  1  kill held and incoming instruction (branch taken)
- out_valid  out  1  ID/EX holds a valid instruction
- out_ready  in  1  execute accepts
- rd1, rd2  out  XLEN  operand values for rs1/rs2
- immOut  out  XLEN  selected immediate (I/S/B/U/J by opcode)
- branch  out  XLEN  B-type byte offset
- jTarget  out  XLEN  J-type byte offset
- out_pc  out  XLEN  registered pc
- out_rd, out_rs1, out_rs2  out  5  register fields
- out_is_load  out  1  opcode == 7'b0000011

Behaviour:
- Reset: out_valid=0; all data outputs 0; register file contents undefined (x0 reads 0); in_ready=1 once reset deasserts.
- Register file:
  - Write on rising clk when RegWrite && wb_rd!=0; writes to x0 are ignored.
  - Reads are combinational.
  - Bypass: if RegWrite && wb_rd!=0 && wb_rd==rs, the read returns wd in the same cycle.
  - When NREG=16, only the low 4 bits of each address are used.
- Immediates, bit 0 included, sign bit ins[31]:
  - I: ins[31:20]
  - S: {ins[31:25],ins[11:7]}
  - B: {ins[31],ins[7],ins[30:25],ins[11:8],1'b0}
  - U: {ins[31:12],12'b0}
  - J: {ins[31],ins[19:12],ins[20],ins[30:21],1'b0}
- immOut selection by opcode:
  - I-format: 0010011, 0000011, 1100111, 1110011
  - S-format: 0100011
  - B-format: 1100011
  - U-format: 0110111, 0010111
  - J-format: 1101111
  - R-format (0110011) and others: 0
- branch and jTarget are always computed regardless of opcode.
- Latency: 1 cycle from accepted input to out_valid.
- Advance: the ID/EX register loads when (!out_valid || out_ready).
- Load-use hazard:
  - Condition: out_valid && out_is_load && out_rd!=0 && (out_rd==rs1 || (uses_rs2 && out_rd==rs2)).
  - uses_rs2 holds for R, S and B formats.
  - On hazard: in_ready=0; if advancing, ID/EX loads a bubble (out_valid=0).
  - The next cycle the hazard clears and the instruction is accepted. Exactly one bubble per hazard.
- in_ready = advance && !hazard && !flush.
- Accept: in_valid && in_ready → ID/EX captures decode results, out_valid=1.
- Advance with no accept: out_valid=0.
- Stall: when out_valid && !out_ready, all outputs hold stable and in_ready=0.
- flush: the next edge forces out_valid=0 and drops any incoming instruction. flush overrides stall and hazard.
- Bypass data is captured into rd1/rd2 at the accept edge; later writes do not update a held ID/EX entry.
- Reset mid-operation: pending instruction is discarded, out_valid=0 next edge; register file is untouched.
- reset has priority over flush, which has priority over everything else.

Optional Feature:
- Macro: ID_ILLEGAL_TRAP_EN.
- Defined: adds output out_illegal (1 bit, registered with the entry).
  - Set when opcode is outside the list above or ins[1:0]!=2'b11.
  - When NREG=16, also set when any used register field has bit 4 set.
  - The entry is still passed down with out_valid=1.
- Undefined: port absent; unknown opcodes decode with immOut=0.

Test Plan:
- Reset, then ins=32'hFFF00093 (addi x1,x0,-1) → one cycle later out_valid=1, immOut=32'hFFFFFFFF, rd1=0, out_rd=1.
- RegWrite=1, wb_rd=5, wd=32'h1234, same cycle ins reads x5 → rd1=32'h1234 (bypass); a write to x0 then a read of x0 → 0.
- Offsets: B-type ins=32'hFE000EE3 → branch=32'hFFFFFFFC; J-type ins=32'h0080006F → jTarget=8; sw ins=32'hFE112E23 → immOut=32'hFFFFFFFC.
- lw x3 followed by add x4,x3,x2 with out_ready=1 → one bubble (out_valid=0 one cycle, in_ready=0), then the add issues; add x4,x2,x3 after lw x3 → also one bubble.
- out_ready=0 for 3 cycles with a valid entry → outputs stable, in_ready=0; flush asserted during the stall → out_valid=0 next edge.
- With ID_ILLEGAL_TRAP_EN, ins=32'h0000007F → out_illegal=1, out_valid=1.
